// File: rtl/v810_ibuf.sv
// v810_ibuf: V810 instruction prefetch buffer; streams aligned words from the MAU
// into a circular queue and serves aligned or straddling EU fetches from it.
module v810_ibuf #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] IA,
    input  logic        IREQ,
    output logic        IACK,
    output logic [31:0] ID,
    output logic [31:0] MIA,
    output logic        MIREQ,
    input  logic        MIACK,
    input  logic [31:0] MID
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, STALE} state_t;

    state_t         state, state_n;
    logic           valid, valid_n, mireq_n;
    logic [29:0]    h, h_n, w, d, t_n;
    logic [CW-1:0]  c, c_n;
    logic [31:0]    mia_n;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wi, wi1, ti;
    logic           flush, drop, wr, unused;

    assign unused = IA[0];
    assign w      = IA[31:2];
    assign d      = w - h;
    assign wi     = w[AW-1:0];
    assign wi1    = wi + 1'b1;
    assign ti     = h[AW-1:0] + c[AW-1:0];
    assign IACK   = IREQ && valid && (IA[1] ? ({1'b0, d} + 31'd1 < 31'(c)) : (d < 30'(c)));
    assign ID     = !IACK ? 32'd0 : IA[1] ? {mem[wi1][15:0], mem[wi][31:16]} : mem[wi];
    assign flush  = IREQ && (!valid || d > 30'(c));
    assign drop   = IREQ && valid && d != 30'd0 && d <= 30'(c);
    // A flush on the acknowledge edge discards the returning word.
    assign wr     = state == BUSY && MIACK && !flush;

    always_comb begin
        valid_n = valid | flush;
        h_n     = (flush || drop) ? w : h;
        c_n     = flush ? '0 : CW'(30'(c) - (drop ? d : 30'd0) + 30'(wr));
        t_n     = h_n + 30'(c_n);
        state_n = state;
        mireq_n = MIREQ;
        mia_n   = MIA;
        case (state)
            IDLE: if (valid_n && c_n < CW'(DEPTH)) begin
                state_n = BUSY;
                mireq_n = 1'b1;
                mia_n   = {t_n, 2'b00};
            end
            BUSY: if (MIACK) begin
                state_n = IDLE;
                mireq_n = 1'b0;
            end else if (flush) begin
                state_n = STALE;
            end
            STALE: if (MIACK) begin
                state_n = IDLE;
                mireq_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state <= IDLE;
            valid <= 1'b0;
            h     <= '0;
            c     <= '0;
            MIREQ <= 1'b0;
            MIA   <= '0;
        end else if (CE) begin
            state <= state_n;
            valid <= valid_n;
            h     <= h_n;
            c     <= c_n;
            MIREQ <= mireq_n;
            MIA   <= mia_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (CE && wr) mem[ti] <= MID;
    end
endmodule

// File: tb/tb_v810_ibuf.sv
// tb_v810_ibuf: scoreboard bench for v810_ibuf with a simple wait-state MAU model.
module tb_v810_ibuf;
    logic        CLK = 0, RES = 1, CE = 1, IREQ = 0, MIACK = 0;
    logic [31:0] IA = 0, MID = 0;
    logic        IACK, MIREQ;
    logic [31:0] ID, MIA;

    int n_chk = 0, n_fail = 0, wait_n = 0, cnt = 0;
    logic [31:0] exp_id[$], exp_mia[$];
    logic        prev_req = 0, prev_ack = 0;
    logic [31:0] prev_mia = 0;

    v810_ibuf dut (.CLK(CLK), .RES(RES), .CE(CE), .IA(IA), .IREQ(IREQ), .IACK(IACK), .ID(ID),
                   .MIA(MIA), .MIREQ(MIREQ), .MIACK(MIACK), .MID(MID));

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'hFFFFFFF0: return 32'h8000BFE0;
            32'h80000000: return 32'h1111AAAA;
            32'h80000004: return 32'h2222BBBB;
            default:      return {a[15:0], a[31:16]} ^ 32'h5A5A0F0F;
        endcase
    endfunction

    function automatic logic [31:0] strad(input logic [31:0] a);
        logic [31:0] lo, hi;
        lo = mem_data(a - 32'd2);
        hi = mem_data(a + 32'd2);
        return {hi[15:0], lo[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] e, input int lat);
        int k = 0;
        bit got = 0;
        exp_id.push_back(e);
        IA = a;
        IREQ = 1;
        while (!got && k < 40) begin
            @(negedge CLK);
            if (IACK) got = 1; else k++;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL fetch_timeout: no IACK for IA=%h within 40 cycles", a);
            exp_id.delete();
        end else if (lat >= 0) chk("fetch_latency", 32'(k), 32'(lat));
        @(posedge CLK);
        #1;
        IREQ = 0;
    endtask

    task automatic push_mia(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_mia.push_back(a + 32'(4 * i));
    endtask

    // MAU: acknowledges after wait_n extra cycles of MIREQ
    initial forever begin
        @(posedge CLK);
        #1;
        if (MIREQ && cnt == wait_n) begin
            MIACK = 1;
            MID = mem_data(MIA);
            cnt = 0;
        end else begin
            MIACK = 0;
            cnt = MIREQ ? cnt + 1 : 0;
        end
    end

    initial forever begin
        @(negedge CLK);
        if (IACK) begin
            if (exp_id.size() == 0) chk("iack_unexpected", {31'd0, IACK}, 32'd0);
            else chk("fetch_data", ID, exp_id.pop_front());
        end
        if (MIREQ && !prev_req) begin
            if (exp_mia.size() == 0) chk("mia_unexpected", MIA, 32'hDEADDEAD);
            else chk("mia_order", MIA, exp_mia.pop_front());
        end else if (MIREQ && !prev_ack) chk("mia_stable", MIA, prev_mia);
        prev_req = MIREQ;
        prev_ack = MIACK;
        prev_mia = MIA;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        IREQ = 1;
        IA = 32'h80000000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_mireq", {31'd0, MIREQ}, 32'd0);
        chk("reset_iack", {31'd0, IACK}, 32'd0);
        chk("reset_id", ID, 32'd0);
        chk("reset_mia", MIA, 32'd0);
        @(posedge CLK);
        #1;
        RES = 0;
        IREQ = 0;
        // cold miss at the top of the address space
        push_mia(32'hFFFFFFF0, 4);
        fetch(32'hFFFFFFF0, 32'h8000BFE0, 2);
        cycles(12);
        chk("full_no_req", {31'd0, MIREQ}, 32'd0);
        // wraparound without flush
        push_mia(32'h00000000, 3);
        fetch(32'hFFFFFFFC, mem_data(32'hFFFFFFFC), 0);
        cycles(10);
        fetch(32'hFFFFFFFE, strad(32'hFFFFFFFE), 0);
        push_mia(32'h0000000C, 1);
        fetch(32'h00000000, mem_data(32'h00000000), 0);
        cycles(6);
        // clock enable low: no flush, no drop, hits still served
        CE = 0;
        IA = 32'h00000040;
        IREQ = 1;
        repeat (4) begin
            @(negedge CLK);
            chk("ce_iack", {31'd0, IACK}, 32'd0);
            chk("ce_mireq", {31'd0, MIREQ}, 32'd0);
        end
        @(posedge CLK);
        #1;
        IREQ = 0;
        fetch(32'h00000004, mem_data(32'h00000004), 0);
        CE = 1;
        fetch(32'h00000000, mem_data(32'h00000000), 0);
        // streaming, straddle hit and drop
        push_mia(32'h80000000, 4);
        fetch(32'h80000000, 32'h1111AAAA, 2);
        cycles(12);
        chk("stream_full", {31'd0, MIREQ}, 32'd0);
        fetch(32'h80000002, 32'hBBBB1111, 0);
        push_mia(32'h80000010, 2);
        fetch(32'h80000008, mem_data(32'h80000008), 0);
        cycles(8);
        // straddle waits for the second word, then branch during BUSY
        wait_n = 3;
        push_mia(32'h80000040, 3);
        fetch(32'h80000042, strad(32'h80000042), 10);
        push_mia(32'h80000100, 4);
        fetch(32'h80000100, mem_data(32'h80000100), 9);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        // async reset in the middle of a MAU request
        exp_mia.delete();
        RES = 1;
        IA = 32'h80000100;
        IREQ = 1;
        #1;
        chk("async_reset_mireq", {31'd0, MIREQ}, 32'd0);
        chk("reset_queue_empty", {31'd0, IACK}, 32'd0);
        cycles(2);
        RES = 0;
        IREQ = 0;
        wait_n = 0;
        push_mia(32'h80000100, 4);
        fetch(32'h80000100, mem_data(32'h80000100), 2);
        cycles(12);
        chk("final_mireq", {31'd0, MIREQ}, 32'd0);
        chk("id_queue_left", 32'(exp_id.size()), 32'd0);
        chk("mia_queue_left", 32'(exp_mia.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
